// File: rtl/tinyalu_issue_ctrl_if.sv
// Issue-controller bus: instruction source side, ALU datapath side, result and error sideband.
// master = environment (source + ALU), slave = tinyalu_issue_ctrl.
interface tinyalu_issue_ctrl_if #(
  parameter int INSTR_W = 19,
  parameter int DATA_W  = 8,
  parameter int RES_W   = 16,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [DATA_W-1:0]  in_a;
  logic [DATA_W-1:0]  in_b;
  logic               start;
  logic [INSTR_W-1:0] instr;
  logic [DATA_W-1:0]  A;
  logic [DATA_W-1:0]  B;
  logic               done;
  logic [RES_W-1:0]   result;
  logic               res_valid;
  logic [RES_W-1:0]   res_data;
  logic [INSTR_W-1:0] res_instr;
  logic               err_timing;
  logic               err_timeout;
  logic               err_opcode;
  logic               err_clr;
  logic [CNT_W-1:0]   count;

  modport master (
    output in_valid, in_instr, in_a, in_b, done, result, err_clr,
    input  in_ready, start, instr, A, B, res_valid, res_data, res_instr,
           err_timing, err_timeout, err_opcode, count
  );

  modport slave (
    input  in_valid, in_instr, in_a, in_b, done, result, err_clr,
    output in_ready, start, instr, A, B, res_valid, res_data, res_instr,
           err_timing, err_timeout, err_opcode, count
  );
endinterface

// File: rtl/tinyalu_issue_ctrl.sv
// TinyALU issue controller: DEPTH-entry instruction FIFO, single-op issue FSM, done-latency/timeout checks.
// Define TINYALU_ISSUE_STRICT_LAT_EN to flag done arriving off its per-opcode latency (err_timing).
module tinyalu_issue_ctrl #(
  parameter int INSTR_W = 19,
  parameter int DATA_W  = 8,
  parameter int RES_W   = 16,
  parameter int DEPTH   = 4,
  parameter int LAT_ALU = 1,
  parameter int LAT_MUL = 3,
  parameter int LAT_SP0 = 4,
  parameter int LAT_MEM = 10,
  parameter int TIMEOUT = 32
) (
  input logic               clk,
  input logic               reset,
  tinyalu_issue_ctrl_if.slave bus
);
  localparam int AW      = $clog2(DEPTH);
  localparam int LAT_M0  = (LAT_ALU > LAT_MUL) ? LAT_ALU : LAT_MUL;
  localparam int LAT_M1  = (LAT_SP0 > LAT_MEM) ? LAT_SP0 : LAT_MEM;
  localparam int LAT_MAX = (LAT_M0 > LAT_M1) ? LAT_M0 : LAT_M1;
  // Wait counter must hold both the timeout and the largest programmed latency.
  localparam int CNT_W   = $clog2(((TIMEOUT > LAT_MAX) ? TIMEOUT : LAT_MAX) + 1);
  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
  } entry_t;

  typedef enum logic {IDLE, BUSY} state_e;

  entry_t             mem_q [DEPTH];
  logic [AW:0]        wptr_q, rptr_q;
  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic               start_q, res_valid_q;
  logic [INSTR_W-1:0] instr_q, res_instr_q;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [RES_W-1:0]   res_data_q;
  logic               err_timeout_q, err_opcode_q;
  entry_t             head;
  logic [3:0]         head_op;
  logic               empty, full, push, pop, reserved;

  assign head     = mem_q[rptr_q[AW-1:0]];
  assign head_op  = head.instr[INSTR_W-1 -: 4];
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push     = bus.in_valid && !full;
  assign pop      = (state_q == IDLE) && !empty;
  assign reserved = (head_op >= 4'hE);
  assign cnt_inc  = cnt_q + 1'b1;

  assign bus.in_ready    = !full;
  assign bus.count       = wptr_q - rptr_q;
  assign bus.start       = start_q;
  assign bus.instr       = instr_q;
  assign bus.A           = a_q;
  assign bus.B           = b_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_instr   = res_instr_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_opcode  = err_opcode_q;

`ifdef TINYALU_ISSUE_STRICT_LAT_EN
  logic [CNT_W-1:0] lat_q;
  logic             err_timing_q;
  assign bus.err_timing = err_timing_q;

  function automatic logic [CNT_W-1:0] lat_of(input logic [3:0] op);
    if (op <= 4'h7)      return CNT_W'(LAT_ALU);
    else if (op <= 4'hA) return CNT_W'(LAT_MUL);
    else if (op == 4'hB) return CNT_W'(LAT_SP0);
    else                 return CNT_W'(LAT_MEM);
  endfunction
`else
  assign bus.err_timing = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= '{bus.in_instr, bus.in_a, bus.in_b};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      start_q       <= 1'b0;
      res_valid_q   <= 1'b0;
      instr_q       <= '0;
      a_q           <= '0;
      b_q           <= '0;
      res_data_q    <= '0;
      res_instr_q   <= '0;
      err_timeout_q <= 1'b0;
      err_opcode_q  <= 1'b0;
`ifdef TINYALU_ISSUE_STRICT_LAT_EN
      lat_q         <= '0;
      err_timing_q  <= 1'b0;
`endif
    end else begin
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      // Clear first so an error raised later in this cycle overrides it.
      if (bus.err_clr) begin
        err_timeout_q <= 1'b0;
        err_opcode_q  <= 1'b0;
`ifdef TINYALU_ISSUE_STRICT_LAT_EN
        err_timing_q  <= 1'b0;
`endif
      end
      case (state_q)
        IDLE: begin
          if (pop) begin
            if (reserved) begin
              err_opcode_q <= 1'b1;
            end else begin
              instr_q <= head.instr;
              a_q     <= head.a;
              b_q     <= head.b;
              start_q <= 1'b1;
              cnt_q   <= '0;
`ifdef TINYALU_ISSUE_STRICT_LAT_EN
              lat_q   <= lat_of(head_op);
`endif
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.done) begin
            res_data_q  <= bus.result;
            res_instr_q <= instr_q;
            res_valid_q <= 1'b1;
`ifdef TINYALU_ISSUE_STRICT_LAT_EN
            if (cnt_inc != lat_q) err_timing_q <= 1'b1;
`endif
            state_q     <= IDLE;
          end else if (cnt_inc == TO_C) begin
            err_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
